namuru_time_base_multi: RTL and testbench

NAMURU_TIME_BASE_MULTI -- requirements
Module: namuru_time_base_multi

---
 rtl/namuru_time_base_multi_pkg.sv | 19 +
 rtl/namuru_tb_channel.sv | 97 +++++++++
 rtl/namuru_time_base_multi.sv | 64 ++++++
 tb/tb_namuru_time_base_multi.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/namuru_time_base_multi_pkg.sv
// Shared constants for the multi-channel Namuru time base: default parameters,
// channel indices and the standard TIC/ACCUM divide values.
package namuru_time_base_multi_pkg;

  localparam int TB_DEF_CW           = 24;
  localparam int TB_DEF_NCH          = 2;
  localparam int TB_DEF_LEAD         = 1;
  localparam int TB_DEF_SDIV         = 5;
  localparam int TB_DEF_SPHASE       = 1;
  localparam bit TB_DEF_RUN_AT_RESET = 1'b1;

  localparam int TB_CH_TIC   = 0;
  localparam int TB_CH_ACCUM = 1;

  // 0.1 s and 0.5 ms periods at a 16.384 MHz sample clock
  localparam logic [23:0] TB_DIV_TIC   = 24'h18FFFF;
  localparam logic [23:0] TB_DIV_ACCUM = 24'h1FFF;

endpackage

// File: rtl/namuru_tb_channel.sv
// One interval channel of the time base: down-counter with shadowed divide,
// run control and a LEAD-deep delay from pre_enable to enable.
module namuru_tb_channel #(
  parameter int CW           = 24,
  parameter int LEAD         = 1,
  parameter bit RUN_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] divide,
  input  logic          divide_wr,
  input  logic          start,
  input  logic          stop,
  input  logic          one_shot,
  output logic          pre_enable,
  output logic          enable,
  output logic [CW-1:0] count,
  output logic          running
);

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   act;
  logic [CW-1:0]   pnd;
  logic            pv;
  logic            run;
  logic            restart;
  logic            reload;
  logic [CW-1:0]   reload_val;
  logic [LEAD-1:0] lead_p;

  assign pre_enable = (cnt == '0) & run;
  assign restart    = start & ~stop;
  assign reload     = pre_enable | restart;
  assign count      = cnt;
  assign running    = run;
  assign enable     = lead_p[LEAD-1];

  // A write landing on the reload cycle bypasses the shadow register
  always_comb begin
    reload_val = act;
    if (divide_wr)
      reload_val = divide;
    else if (pv)
      reload_val = pnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '1;
      act <= '1;
      pv  <= 1'b0;
      run <= RUN_AT_RESET;
    end else begin
      if (reload) begin
        cnt <= reload_val;
        act <= reload_val;
        pv  <= 1'b0;
      end else begin
        if (divide_wr)
          pv <= 1'b1;
        if (run)
          cnt <= cnt - 1'b1;
      end
      if (stop)
        run <= 1'b0;
      else if (start)
        run <= 1'b1;
      else if (pre_enable && one_shot)
        run <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (divide_wr && !reload)
      pnd <= divide;
  end

  // pre_enable -> enable delay line, drains normally after stop
  generate
    if (LEAD == 1) begin : g_lead1
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lead_p <= '0;
        else
          lead_p <= pre_enable;
      end
    end else begin : g_leadn
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          lead_p <= '0;
        else
          lead_p <= {lead_p[LEAD-2:0], pre_enable};
      end
    end
  endgenerate

endmodule

// File: rtl/namuru_time_base_multi.sv
// Multi-channel time base: NCH independent interval channels plus a free-running
// mod-SDIV sample-enable divider.
module namuru_time_base_multi
  import namuru_time_base_multi_pkg::*;
#(
  parameter int CW           = TB_DEF_CW,
  parameter int NCH          = TB_DEF_NCH,
  parameter int LEAD         = TB_DEF_LEAD,
  parameter int SDIV         = TB_DEF_SDIV,
  parameter int SPHASE       = TB_DEF_SPHASE,
  parameter bit RUN_AT_RESET = TB_DEF_RUN_AT_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*CW-1:0] divide,
  input  logic [NCH-1:0]    divide_wr,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    one_shot,
  output logic              sample_enable,
  output logic [NCH-1:0]    pre_enable,
  output logic [NCH-1:0]    enable,
  output logic [NCH*CW-1:0] count,
  output logic [NCH-1:0]    running
);

  localparam int SW = $clog2(SDIV);

  logic [SW-1:0] sample_cnt;

  assign sample_enable = (sample_cnt == SW'(SPHASE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sample_cnt <= '0;
    else if (sample_cnt == SW'(SDIV - 1))
      sample_cnt <= '0;
    else
      sample_cnt <= sample_cnt + 1'b1;
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      namuru_tb_channel #(
        .CW           (CW),
        .LEAD         (LEAD),
        .RUN_AT_RESET (RUN_AT_RESET)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .divide     (divide[i*CW +: CW]),
        .divide_wr  (divide_wr[i]),
        .start      (start[i]),
        .stop       (stop[i]),
        .one_shot   (one_shot[i]),
        .pre_enable (pre_enable[i]),
        .enable     (enable[i]),
        .count      (count[i*CW +: CW]),
        .running    (running[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_namuru_time_base_multi.sv
// Bench for namuru_time_base_multi: directed scenarios plus random strobes,
// checked every cycle against a behavioural model of the channel rules.
module tb_namuru_time_base_multi;
  import namuru_time_base_multi_pkg::*;

  localparam int CW     = 8;
  localparam int NCH    = 3;
  localparam int LEAD   = 3;
  localparam int SDIV   = 5;
  localparam int SPHASE = 1;
  localparam int ONES   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*CW-1:0] divide;
  logic [NCH-1:0]    divide_wr, start, stop, one_shot;
  logic              sample_enable;
  logic [NCH-1:0]    pre_enable, enable, running;
  logic [NCH*CW-1:0] count;

  namuru_time_base_multi #(
    .CW(CW), .NCH(NCH), .LEAD(LEAD), .SDIV(SDIV), .SPHASE(SPHASE), .RUN_AT_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .divide(divide), .divide_wr(divide_wr), .start(start),
    .stop(stop), .one_shot(one_shot), .sample_enable(sample_enable),
    .pre_enable(pre_enable), .enable(enable), .count(count), .running(running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counter values per channel, cycle index since reset,
  // and a log of the cycles in which each channel hit terminal count.
  int m_cnt [NCH];
  int m_act [NCH];
  int m_pnd [NCH];
  bit m_pv  [NCH];
  bit m_run [NCH];
  int scnt;
  bit tc_log [int];

  function automatic bit m_pre(int ch);
    return (m_cnt[ch] == 0) && m_run[ch];
  endfunction

  function automatic bit m_en(int ch);
    int t = scnt - LEAD;
    if (t < 0) return 1'b0;
    return tc_log.exists(t * NCH + ch);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = ONES; m_act[c] = ONES; m_pnd[c] = 0; m_pv[c] = 0; m_run[c] = 1;
    end
    scnt = 0;
    tc_log.delete();
  endtask

  // Apply one clock of the channel rules to the model using the current inputs
  task automatic model_clock();
    for (int c = 0; c < NCH; c++) begin
      bit tc   = m_pre(c);
      bit wr   = divide_wr[c];
      int dval = int'(divide[c*CW +: CW]);
      if (tc) tc_log[scnt * NCH + c] = 1'b1;
      if (tc || (start[c] && !stop[c])) begin
        if (wr)         m_act[c] = dval;
        else if (m_pv[c]) m_act[c] = m_pnd[c];
        m_cnt[c] = m_act[c];
        m_pv[c]  = 0;
      end else begin
        if (wr) begin m_pnd[c] = dval; m_pv[c] = 1; end
        if (m_run[c]) m_cnt[c] = m_cnt[c] - 1;
      end
      if (stop[c])                 m_run[c] = 0;
      else if (start[c])           m_run[c] = 1;
      else if (tc && one_shot[c])  m_run[c] = 0;
    end
    scnt++;
  endtask

  task automatic check_all();
    chk($sformatf("sample_enable@%0d", scnt), 32'(sample_enable), 32'((scnt % SDIV) == SPHASE));
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("pre_enable[%0d]@%0d", c, scnt), 32'(pre_enable[c]), 32'(m_pre(c)));
      chk($sformatf("enable[%0d]@%0d", c, scnt), 32'(enable[c]), 32'(m_en(c)));
      chk($sformatf("count[%0d]@%0d", c, scnt), 32'(count[c*CW +: CW]), 32'(m_cnt[c]));
      chk($sformatf("running[%0d]@%0d", c, scnt), 32'(running[c]), 32'(m_run[c]));
    end
  endtask

  task automatic step();
    check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    divide_wr = '0;
    start     = '0;
    stop      = '0;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(int ch, int val);
    divide[ch*CW +: CW] = CW'(val);
    divide_wr[ch] = 1'b1;
  endtask

  task automatic run_until_tc(int ch, int maxc, output int n);
    n = 0;
    while (!m_pre(ch) && n < maxc) begin step(); n++; end
    chk($sformatf("wait_tc[%0d]", ch), 32'(pre_enable[ch]), 32'd1);
  endtask

  int n;

  initial begin
    rst = 1'b1; divide = '0; divide_wr = '0; start = '0; stop = '0; one_shot = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Reset state, then first TC at 2^CW cycles with a pending divide of 3
    chk("reset_count0", 32'(count[TB_CH_TIC*CW +: CW]), 32'hFF);
    steps(100);
    wr(TB_CH_TIC, 3);
    while (scnt < 255) step();
    chk("first_tc_cycle256", 32'(pre_enable[TB_CH_TIC]), 32'd1);
    steps(20);

    // Divide 9, change to 4 mid-period, then a write coincident with TC
    wr(0, 9); start[0] = 1'b1; step();
    run_until_tc(0, 20, n); step();
    steps(4); wr(0, 4); step();
    steps(30);
    run_until_tc(0, 10, n);
    wr(0, 6); step();
    chk("bypass_count", 32'(count[0 +: CW]), 32'd6);
    steps(15);

    // One-shot with act=7
    stop = '1; step();
    one_shot[0] = 1'b1; wr(0, 7); step();
    start[0] = 1'b1; step();
    run_until_tc(0, 10, n);
    chk("oneshot_delay", 32'(n), 32'd7);
    steps(12);
    one_shot[0] = 1'b0;
    chk("oneshot_running", 32'(running[0]), 32'd0);
    chk("oneshot_hold", 32'(count[0 +: CW]), 32'd7);

    // Start and stop together, then restart mid-period with act=5
    start[1] = 1'b1; stop[1] = 1'b1; step();
    chk("start_stop_running", 32'(running[1]), 32'd0);
    wr(1, 5); start[1] = 1'b1; step();
    steps(3);
    start[1] = 1'b1; step();
    run_until_tc(1, 10, n);
    chk("restart_delay", 32'(n), 32'd5);
    steps(3);

    // Three independent channels with divides 2, 3, 4
    wr(0, 2); wr(1, 3); wr(2, 4); start = '1; step();
    steps(60);

    // Asynchronous reset while an enable pulse is in flight
    run_until_tc(0, 10, n);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("rst_pre_enable", 32'(pre_enable), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_sample", 32'(sample_enable), 32'd0);
    chk("rst_count", 32'(count), 32'hFFFFFF);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    steps(10);

    // Random strobes and divides
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(15) == 0) wr(c, int'($urandom_range(12)));
        if ($urandom_range(19) == 0) start[c] = 1'b1;
        if ($urandom_range(39) == 0) stop[c] = 1'b1;
        if ($urandom_range(49) == 0) one_shot[c] = ~one_shot[c];
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
